// File: rtl/store_align_queue.sv
// Store path: lane alignment, misalignment rejection and an in-order store queue draining to data memory.
// Optional combinational store-to-load forwarding is built when STORE_FWD_EN is defined.

package operations;
  typedef enum logic [1:0] {
    SPL_SB = 2'd0,
    SPL_SH = 2'd1,
    SPL_SW = 2'd2,
    SPL_SD = 2'd3
  } spl_size_e;
endpackage

module store_align_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  localparam int STRB = XLEN / 8,
  localparam int LSB  = $clog2(STRB),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_size,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_flush,
  output logic            o_misaligned,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_addr,
  output logic [XLEN-1:0] o_wdata,
  output logic [STRB-1:0] o_wstrb,
  output logic [CW-1:0]   o_count,
  input  logic [XLEN-1:0] i_ld_addr,
  output logic            o_fwd_hit,
  output logic [XLEN-1:0] o_fwd_data,
  output logic [STRB-1:0] o_fwd_strb
);
  import operations::*;

  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [STRB-1:0] strb_mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            mis_q;

  logic            misaligned;
  logic [XLEN-1:0] al_data;
  logic [STRB-1:0] al_strb;
  logic            enq, deq, reject;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    int nbytes;
    int offset;
    nbytes  = 1;
    offset  = int'(i_addr[LSB-1:0]);
    al_data = '0;
    al_strb = '0;
    case (spl_size_e'(i_size))
      SPL_SB:  nbytes = 1;
      SPL_SH:  nbytes = 2;
      SPL_SW:  nbytes = 4;
      default: nbytes = 8;
    endcase
    misaligned = (nbytes > STRB) || ((offset % nbytes) != 0);
    for (int b = 0; b < STRB; b++) begin
      if (b >= offset && b < offset + nbytes) begin
        al_strb[b]       = 1'b1;
        al_data[8*b +: 8] = i_data[8*(b-offset) +: 8];
      end
    end
  end

  assign o_ready = (count < CW'(DEPTH));
  assign o_valid = (count != '0);
  assign reject  = i_valid && o_ready && misaligned;
  assign enq     = i_valid && o_ready && !misaligned && !i_flush;
  assign deq     = o_valid && i_ready;

  // NOTE: the storage is reset because the head outputs read straight from it
  // and must be zero out of reset; a bare RAM without reset would expose X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      mis_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        strb_mem[i] <= '0;
      end
    end else begin
      mis_q <= reject;
      if (i_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          addr_mem[tail] <= {i_addr[XLEN-1:LSB], {LSB{1'b0}}};
          data_mem[tail] <= al_data;
          strb_mem[tail] <= al_strb;
          tail           <= tail + PW'(1);
        end
        if (deq) head <= head + PW'(1);
        case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign o_misaligned = mis_q;
  assign o_count      = count;
  assign o_addr       = addr_mem[head];
  assign o_wdata      = data_mem[head];
  assign o_wstrb      = strb_mem[head];

`ifdef STORE_FWD_EN
  // Walk oldest to youngest so the youngest matching entry overwrites each byte.
  always_comb begin
    logic [XLEN-1:0] ld_word;
    logic [PW-1:0]   idx;
    ld_word    = {i_ld_addr[XLEN-1:LSB], {LSB{1'b0}}};
    idx        = '0;
    o_fwd_data = '0;
    o_fwd_strb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr_mem[idx] == ld_word) begin
        for (int b = 0; b < STRB; b++) begin
          if (strb_mem[idx][b]) begin
            o_fwd_strb[b]       = 1'b1;
            o_fwd_data[8*b +: 8] = data_mem[idx][8*b +: 8];
          end
        end
      end
    end
  end
  assign o_fwd_hit = |o_fwd_strb;
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^i_ld_addr;
  assign o_fwd_hit      = 1'b0;
  assign o_fwd_data     = '0;
  assign o_fwd_strb     = '0;
`endif

endmodule

// File: tb/tb_store_align_queue.sv
// Self-checking bench for store_align_queue: a queue-based reference model compared every cycle,
// plus directed literal checks; a second XLEN=32 instance covers the SD-too-wide case.

module tb_store_align_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, flush, misaligned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_data, ld_addr;
  logic        mem_valid, mem_ready, fwd_hit;
  logic [63:0] mem_addr, mem_wdata, fwd_data;
  logic [7:0]  mem_wstrb, fwd_strb;
  logic [2:0]  count;

  logic        v32, rdy32, mis32, mval32, hit32;
  logic [1:0]  size32;
  logic [31:0] addr32, data32, maddr32, mdata32, fdata32;
  logic [3:0]  mstrb32, fstrb32;
  logic [2:0]  count32;

  int checks = 0;
  int failures = 0;

  ent_t mq[$];
  logic exp_mis;

  always #5 clk = ~clk;

  store_align_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(req_valid), .o_ready(req_ready),
    .i_size(req_size), .i_addr(req_addr), .i_data(req_data), .i_flush(flush),
    .o_misaligned(misaligned), .o_valid(mem_valid), .i_ready(mem_ready),
    .o_addr(mem_addr), .o_wdata(mem_wdata), .o_wstrb(mem_wstrb), .o_count(count),
    .i_ld_addr(ld_addr), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_fwd_strb(fwd_strb)
  );

  store_align_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
    .i_size(size32), .i_addr(addr32), .i_data(data32), .i_flush(1'b0),
    .o_misaligned(mis32), .o_valid(mval32), .i_ready(1'b1),
    .o_addr(maddr32), .o_wdata(mdata32), .o_wstrb(mstrb32), .o_count(count32),
    .i_ld_addr(32'h0), .o_fwd_hit(hit32), .o_fwd_data(fdata32), .o_fwd_strb(fstrb32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t make_entry(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
    ent_t e;
    int n, off;
    logic [63:0] mask;
    n    = 1 << sz;
    off  = int'(a % 8);
    mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    e.addr = a & ~64'h7;
    e.data = (d & mask) << (8 * off);
    e.strb = 8'(((1 << n) - 1) << off);
    return e;
  endfunction

  // Reference model: a plain queue updated by the handshake rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_mis = 1'b0;
    end else begin
      bit full, mis;
      int n;
      full    = (mq.size() == DEPTH);
      n       = 1 << req_size;
      mis     = (n > XLEN / 8) || ((req_addr % n) != 0);
      exp_mis = req_valid && !full && mis;
      if (flush) mq.delete();
      else begin
        if (mq.size() != 0 && mem_ready) void'(mq.pop_front());
        if (req_valid && !full && !mis) mq.push_back(make_entry(req_size, req_addr, req_data));
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] fd;
    logic [7:0]  fs;
    check("o_valid", 64'(mem_valid), 64'(mq.size() != 0));
    check("o_count", 64'(count), 64'(mq.size()));
    check("o_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
    check("o_misaligned", 64'(misaligned), 64'(exp_mis));
    if (mq.size() != 0) begin
      check("o_addr", mem_addr, mq[0].addr);
      check("o_wdata", mem_wdata, mq[0].data);
      check("o_wstrb", 64'(mem_wstrb), 64'(mq[0].strb));
    end
    fd = '0;
    fs = '0;
`ifdef STORE_FWD_EN
    foreach (mq[i]) begin
      if (mq[i].addr == (ld_addr & ~64'h7))
        for (int b = 0; b < 8; b++)
          if (mq[i].strb[b]) begin
            fs[b] = 1'b1;
            fd[8*b +: 8] = mq[i].data[8*b +: 8];
          end
    end
`endif
    check("o_fwd_strb", 64'(fwd_strb), 64'(fs));
    check("o_fwd_data", fwd_data, fd);
    check("o_fwd_hit", 64'(fwd_hit), 64'(fs != 0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    mem_ready = 1'b1;
    k = 0;
    while (count != 0 && k < 16) begin
      cyc();
      k++;
    end
    check("drain_empty", 64'(count), 64'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    bit rdy;
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_size = 2'd0; req_addr = '0; req_data = '0;
    flush = 1'b0; mem_ready = 1'b0; ld_addr = 64'h3004;
    v32 = 1'b0; size32 = 2'd0; addr32 = '0; data32 = '0;
    cyc();
    cyc();
    check("rst_o_valid", 64'(mem_valid), 64'd0);
    check("rst_o_addr", mem_addr, 64'd0);
    check("rst_o_wdata", mem_wdata, 64'd0);
    check("rst_o_wstrb", 64'(mem_wstrb), 64'd0);
    rst_n = 1'b1;
    cyc();

    // SB with byte offset 3.
    store(2'd0, 64'h1003, 64'hAB);
    check("sb_valid", 64'(mem_valid), 64'd1);
    check("sb_addr", mem_addr, 64'h1000);
    check("sb_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
    check("sb_wstrb", 64'(mem_wstrb), 64'h08);
    check("sb_count", 64'(count), 64'd1);
    drain();

    // Misaligned SW on 64-bit and SD on 32-bit.
    v32 = 1'b1; size32 = 2'd3; addr32 = 32'h2000; data32 = 32'h1234_5678;
    store(2'd2, 64'h2006, 64'hDEAD_BEEF);
    v32 = 1'b0;
    check("mis_pulse", 64'(misaligned), 64'd1);
    check("mis_count", 64'(count), 64'd0);
    check("mis32_pulse", 64'(mis32), 64'd1);
    check("mis32_count", 64'(count32), 64'd0);
    cyc();
    check("mis_drop", 64'(misaligned), 64'd0);
    check("mis32_drop", 64'(mis32), 64'd0);
    v32 = 1'b1; size32 = 2'd2; addr32 = 32'h2004;
    cyc();
    v32 = 1'b0;
    check("sw32_accept", 64'(count32), 64'd1);
    check("sw32_strb", 64'(mstrb32), 64'hF);
    check("sw32_mis", 64'(mis32), 64'd0);

    // Fill with SH stores, stall, then drain with wrap and accept the 5th.
    for (int i = 0; i < 4; i++) store(2'd1, 64'h4000 + 64'(2 * i), 64'hA0A0 + 64'(i));
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    req_valid = 1'b1; req_size = 2'd1; req_addr = 64'h4008; req_data = 64'hA0A4;
    mem_ready = 1'b1;
    k = 0;
    do begin
      rdy = req_ready;
      cyc();
      k++;
    end while (!rdy && k < 8);
    req_valid = 1'b0;
    check("fifth_accepted", 64'(rdy), 64'd1);
    drain();

    // Simultaneous enqueue and dequeue keeps occupancy.
    store(2'd2, 64'h5000, 64'h1111_1111);
    store(2'd2, 64'h5004, 64'h2222_2222);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(2'd2, 64'h5008 + 64'(4 * i), 64'h3333_3333 + 64'(i));
      check("enq_deq_count", 64'(count), 64'd2);
    end
    drain();

    // Flush overrides a concurrent store.
    for (int i = 0; i < 3; i++) store(2'd0, 64'h6000 + 64'(i), 64'h10 + 64'(i));
    flush = 1'b1;
    store(2'd3, 64'h6008, 64'h0123_4567_89AB_CDEF);
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(mem_valid), 64'd0);
    cyc();
    check("flush_no_enq", 64'(count), 64'd0);

    // Forwarding: SD then younger SB in the same word.
    store(2'd3, 64'h3000, 64'h1122_3344_5566_7788);
    store(2'd0, 64'h3001, 64'hFF);
    ld_addr = 64'h3004;
    #1;
`ifdef STORE_FWD_EN
    check("fwd_strb", 64'(fwd_strb), 64'hFF);
    check("fwd_data", fwd_data, 64'h1122_3344_5566_FF88);
    check("fwd_hit", 64'(fwd_hit), 64'd1);
    ld_addr = 64'h3008;
    #1;
    check("fwd_miss", 64'(fwd_strb), 64'd0);
    ld_addr = 64'h3004;
`else
    check("fwd_off_strb", 64'(fwd_strb), 64'd0);
    check("fwd_off_data", fwd_data, 64'd0);
    check("fwd_off_hit", 64'(fwd_hit), 64'd0);
`endif

    // Reset mid-drain drops everything.
    mem_ready = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(mem_valid), 64'd0);
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_addr", mem_addr, 64'd0);
    check("rst_mid_wdata", mem_wdata, 64'd0);
    check("rst_mid_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_mid_fwd", 64'(fwd_strb), 64'd0);
    mem_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_count", 64'(count), 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
